// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and sizing helpers for the serial subtractor
package sub_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sub_state_t;

  // A one-slice configuration still needs a 1-bit index register
  function automatic int idx_w(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/slice_subtractor.sv
// rtl/slice_subtractor.sv - combinational W-bit a - b - borrow_in slice
module slice_subtractor #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] sum;

  // a + ~b + ~borrow_in: carry out of the top bit means no borrow was needed
  always_comb begin
    sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~borrow_in};
  end

  assign diff       = sum[W-1:0];
  assign borrow_out = ~sum[W];

endmodule

// File: rtl/serial_subtractor_32bit.sv
// rtl/serial_subtractor_32bit.sv - multi-cycle a - b - bin, one slice per clock, LSB first
// Optional signed-overflow output ovf when SUB_OVF_EN is defined.
module serial_subtractor_32bit
  import sub_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int IW         = idx_w(NUM_SLICES);

  generate
    if ((WIDTH % SLICE_W) != 0) begin : g_bad_slice
      $error("SLICE_W must divide WIDTH exactly");
    end
  endgenerate

  sub_state_t       state;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             borrow;
  logic [IW-1:0]    idx;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_diff;
  logic               sl_borrow;

  assign sl_a = a_s[idx*SLICE_W +: SLICE_W];
  assign sl_b = b_s[idx*SLICE_W +: SLICE_W];

  slice_subtractor #(
    .W (SLICE_W)
  ) u_slice (
    .a          (sl_a),
    .b          (sl_b),
    .borrow_in  (borrow),
    .diff       (sl_diff),
    .borrow_out (sl_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_s    <= '0;
      b_s    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle itself does not accept a new request
          if (start && !done) begin
            a_s    <= a;
            b_s    <= b;
            borrow <= bin;
            idx    <= '0;
            d      <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          d[idx*SLICE_W +: SLICE_W] <= sl_diff;
          borrow                    <= sl_borrow;
          if (idx == IW'(NUM_SLICES - 1)) begin
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b1;
          bout  <= borrow;
`ifdef SUB_OVF_EN
          ovf   <= (a_s[WIDTH-1] != b_s[WIDTH-1]) && (d[WIDTH-1] != a_s[WIDTH-1]);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
